// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo shared types: op codes, FSM states, counter sizing.
// Imported by the MDU control/datapath and the bench.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_WIDTH = 32;

  function automatic int mdu_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo request/result bundle.
// master drives operands and commands, slave returns HI/LO status.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mdu_hilo_sign_fix.sv
// Final HI/LO formation from unsigned iteration results.
// Applies result signs and the divide-by-zero override.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic               dz,
  input  logic [WIDTH-1:0]   a_orig,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rem,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  // select product, divide-by-zero pattern or signed quotient/remainder
  always_comb begin
    hi = '0;
    lo = '0;
    unique case (1'b1)
      !is_div: begin
        {hi, lo} = neg_q ? -prod : prod;
      end
      is_div && dz: begin
        hi = a_orig;
        lo = '1;
      end
      is_div && !dz: begin
        lo = neg_q ? -quot : quot;
        hi = neg_r ? -rem : rem;
      end
      default: begin
        hi = '0;
        lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One product or quotient bit per cycle; signs fixed in a final cycle.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_hilo_if.slave bus
);

  localparam int CW = mdu_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               busy_q;
  logic               done_q;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    sa   = ~bus.op[0] & bus.a[WIDTH-1];
    sb   = ~bus.op[0] & bus.b[WIDTH-1];
    ma   = sa ? -bus.a : bus.a;
    mb   = sb ? -bus.b : bus.b;
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (acc[0] ? {1'b0, mcand} : '0);
    shl  = {rem, acc[WIDTH-1]};
    diff = shl - {1'b0, mcand};
  end

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_fix (
    .is_div (div_q),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .dz     (dz),
    .a_orig (a_orig),
    .prod   (acc),
    .quot   (acc[WIDTH-1:0]),
    .rem    (rem),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  // control FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      acc    <= '0;
      mcand  <= '0;
      rem    <= '0;
      a_orig <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        MDU_IDLE: begin
          if (bus.start) begin
            div_q  <= bus.op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= bus.op[1] && (bus.b == '0);
            a_orig <= bus.a;
            mcand  <= bus.op[1] ? mb : ma;
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? ma : mb};
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MDU_CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.a;
            if (bus.mtlo) lo_q <= bus.a;
          end
        end
        MDU_CALC: begin
          if (div_q) begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shl[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {msum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= MDU_FIX;
        end
        MDU_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= MDU_IDLE;
        end
        default: begin
          state <= MDU_IDLE;
        end
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO registers, sitting beside the ALU in the execute stage of the multicycle CPU. It executes MULT, MULTU, DIV and DIVU using register-file operands, and services MTHI/MTLO writes. HI and LO are fed back to the register-file write mux for MFHI/MFLO. The controller FSM holds in its execute state while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation in `op`. Sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand or dividend).
- `b`  in  WIDTH  rt operand (multiplier or divisor).
- `mthi`  in  1  write `a` into HI.
- `mtlo`  in  1  write `a` into LO.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, on `start`:
  - Latch absolute values of `a` and `b` (raw values for MULTU/DIVU).
  - Latch `op`, the result-sign flags and the divide-by-zero flag (`b==0` on DIV/DIVU).
  - Clear the counter and go to CALC.
- CALC, MULT/MULTU: shift-add, 1 multiplier bit per cycle into a 2·WIDTH accumulator.
- CALC, DIV/DIVU: restoring division, 1 quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- CALC lasts exactly WIDTH cycles, then go to FIX.
- FIX: apply signs and write HI/LO, then return to IDLE with `done`=1 for one cycle.
  - Multiply: {HI,LO} = product, negated if the operand signs differ (MULT only).
  - Divide: LO = quotient, negated if the signs differ. HI = remainder, taking the dividend's sign.
- Divide by zero (DIV or DIVU): LO = all ones, HI = original `a`, unsigned or signed.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural WIDTH-bit wrap; no trap is raised.
- MTHI/MTLO:
  - Honoured only in IDLE, when `start` is low. They write on the next edge.
  - Both may be asserted together; both registers are written.
- Simultaneous events in IDLE: `start` wins and MTHI/MTLO are dropped.
- Ignored while busy: `start`, `mthi` and `mtlo` in CALC/FIX. Operand changes after the start edge have no effect.
- `hi` and `lo` are always driven, never Z. They hold their value except at the FIX write or an MT write.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-operation: the operation is aborted immediately (asynchronous). No HI/LO write occurs and the registers return to 0.
- Start sampled at edge k:
  - `busy`=1 after edges k through k+WIDTH.
  - HI/LO updated, `done`=1 and `busy`=0 after edge k+WIDTH+1.
  - 33 edges total for WIDTH=32.
- `done` falls after the next edge unless a new start was accepted at that edge. If a new start is accepted, `done` still falls and `busy` rises.
- Back-to-back: a `start` during the `done` cycle is accepted, since the unit is in IDLE.
- MT write: visible on `hi`/`lo` one edge after `mthi`/`mtlo` is sampled.
- `busy` and `done` are registered outputs; no combinational path from inputs.

## Structure
- Package `mdu_pkg`:
  - Op codes `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - State encoding `MDU_IDLE`, `MDU_CALC`, `MDU_FIX`.
  - Counter width `$clog2(WIDTH)+1`.
- Sub-module `mdu_sign_fix`: combinational. It takes the raw product or quotient/remainder, the sign flags, the divide-by-zero flag and the original dividend, and outputs final HI/LO. It is instantiated once and feeds the FIX write.
- Control and iteration datapath are in the top level. Target is about 200 lines in total.

## Test plan
- Signed multiply: MULT `a`=0xFFFFFFFD (−3), `b`=5 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done` pulses once.
- Unsigned multiply: MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Also MULT on the same operands → HI=0, LO=1.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234. DIV 0xFFFFFFF0/0 → LO=0xFFFFFFFF, HI=0xFFFFFFF0.
- Control edge cases:
  - `mthi`+`mtlo` in IDLE with `a`=0xA5A5A5A5 → both registers = 0xA5A5A5A5 one edge later.
  - `start` and `mthi` asserted during CALC are ignored.
  - `rst_n` pulsed low at cycle 10 of an operation → `busy`=0, HI=LO=0, no `done`.
